// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - instruction issue sequencer between Fetcher and Decoder
//
// Buffers fetched instructions in a small FIFO, presents the head to the
// Decoder and issues it to RS or LSB when the RoB and the target unit have room.
// Unknown opcodes are dropped with a one-cycle illegal_instr pulse.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rdy                 global enable; low freezes all state and blocks issue
//   clear               mispredict flush from RoB
//   instr_ready         Fetcher delivers instr_in/instr_addr_in this cycle
//   fetch_stall         registered back-pressure to the Fetcher
//   dec_valid/instr/addr head entry presented to the Decoder
//   rob_full/rs_full/lsb_full  downstream occupancy
//   instr_issued, issue_to_rs, issue_to_lsb  issue handshake and steering
//   illegal_instr       head dropped because of an unknown opcode
module issue_ctrl #(
  parameter int QUEUE_DEPTH = 2,
  parameter int QUEUE_WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        instr_ready,
  input  logic [31:0] instr_in,
  input  logic [31:0] instr_addr_in,
  output logic        fetch_stall,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_addr,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        lsb_full,
  output logic        instr_issued,
  output logic        issue_to_rs,
  output logic        issue_to_lsb,
  output logic        illegal_instr
);

  localparam logic [QUEUE_WIDTH:0] DEPTH_C    = (QUEUE_WIDTH+1)'(QUEUE_DEPTH);
  localparam logic [QUEUE_WIDTH:0] DEPTH_M1_C = (QUEUE_WIDTH+1)'(QUEUE_DEPTH - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [QUEUE_WIDTH-1:0] head_q, head_d;
  logic [QUEUE_WIDTH-1:0] tail_q, tail_d;
  logic [QUEUE_WIDTH:0]   count_q, count_d;
  logic                   fetch_stall_q, fetch_stall_d;

  logic [31:0] instr_mem_q [QUEUE_DEPTH];
  logic [31:0] addr_mem_q  [QUEUE_DEPTH];

  logic not_empty;
  logic head_rs;
  logic head_lsb;
  logic issue_ok;
  logic illegal_ok;
  logic push;
  logic pop;

  // Head presentation; data is forced to zero while the buffer is empty so
  // stale storage never reaches the Decoder.
  assign not_empty = (count_q != '0);
  assign dec_valid = not_empty && (state_q == ST_RUN);
  assign dec_instr = not_empty ? instr_mem_q[head_q] : 32'h0;
  assign dec_addr  = not_empty ? addr_mem_q[head_q]  : 32'h0;

  always_comb begin
    head_rs  = 1'b0;
    head_lsb = 1'b0;
    case (dec_instr[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b1100011, 7'b0010011, 7'b0110011: head_rs  = 1'b1;
      7'b0000011, 7'b0100011:             head_lsb = 1'b1;
      default: ;
    endcase
  end

  // Illegal heads are discarded regardless of downstream fullness, since
  // they never occupy a RoB, RS or LSB slot.
  assign issue_ok   = dec_valid && rdy && !clear && !rob_full &&
                      (head_rs ? !rs_full : (head_lsb ? !lsb_full : 1'b0));
  assign illegal_ok = dec_valid && rdy && !clear && !head_rs && !head_lsb;

  assign instr_issued  = issue_ok;
  assign issue_to_rs   = issue_ok && head_rs;
  assign issue_to_lsb  = issue_ok && head_lsb;
  assign illegal_instr = illegal_ok;
  assign fetch_stall   = fetch_stall_q;

  assign pop  = issue_ok || illegal_ok;
  // A push into a full buffer is dropped; the Fetcher is expected to obey
  // fetch_stall, which warns one entry before the buffer fills.
  assign push = instr_ready && rdy && !clear && (state_q == ST_RUN) &&
                (count_q < DEPTH_C);

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fetch_stall_d = fetch_stall_q;
    if (rdy) begin
      if (clear) begin
        // Flush wins over any push/pop on the same edge.
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        state_d = ST_FLUSH;
      end else begin
        // FLUSH lasts exactly one cycle unless clear is reasserted.
        state_d = ST_RUN;
        if (pop) begin
          head_d = head_q + QUEUE_WIDTH'(1);
        end
        if (push) begin
          tail_d = tail_q + QUEUE_WIDTH'(1);
        end
        case ({push, pop})
          2'b10:   count_d = count_q + (QUEUE_WIDTH+1)'(1);
          2'b01:   count_d = count_q - (QUEUE_WIDTH+1)'(1);
          default: ;
        endcase
      end
      fetch_stall_d = (count_d >= DEPTH_M1_C) || (state_d == ST_FLUSH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_stall_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fetch_stall_q <= fetch_stall_d;
    end
  end

  // Storage needs no reset: it is only observed while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[tail_q] <= instr_in;
      addr_mem_q[tail_q]  <= instr_addr_in;
    end
  end

endmodule
